// File: rtl/coeff_pkg.sv
// Shared constants, state encoding and sizing helper for the runtime FIR coefficient loader.
package coeff_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } coeff_state_t;

  function automatic int bytes_per_coeff(input int coeff_width);
    return coeff_width / 8;
  endfunction

endpackage

// File: rtl/coeff_loader_if.sv
// Byte-stream valid/ready channel (with synchronous abort) feeding the coefficient loader.
interface coeff_loader_if;
  logic [7:0] InByte;
  logic       InValid;
  logic       InReady;
  logic       Abort;

  modport master (output InByte, output InValid, output Abort, input InReady);
  modport slave  (input InByte, input InValid, input Abort, output InReady);
endinterface

// File: rtl/coeff_word_assembler.sv
// Packs little-endian bytes into one coefficient word; WordDone flags the accept of its last byte.
module coeff_word_assembler
  import coeff_pkg::*;
#(
  parameter int COEFFDATAWIDTH = 32
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      clear_i,
  input  logic                      accept_i,
  input  logic [7:0]                byte_i,
  output logic [COEFFDATAWIDTH-1:0] word_o,
  output logic                      WordDone
);

  localparam int BPC = bytes_per_coeff(COEFFDATAWIDTH);
  localparam int BW  = (BPC > 1) ? $clog2(BPC) : 1;

  logic [BW-1:0]             byte_idx_q, byte_idx_d;
  logic [COEFFDATAWIDTH-1:0] word_q;

  // word_o already contains the byte being accepted, so the top can store it on WordDone.
  always_comb begin
    word_o = word_q;
    for (int b = 0; b < BPC; b++) begin
      if (byte_idx_q == BW'(b)) word_o[8*b +: 8] = byte_i;
    end
  end

  assign WordDone = accept_i && (byte_idx_q == BW'(BPC - 1));

  always_comb begin
    byte_idx_d = byte_idx_q;
    if (clear_i)       byte_idx_d = '0;
    else if (WordDone) byte_idx_d = '0;
    else if (accept_i) byte_idx_d = byte_idx_q + BW'(1);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      byte_idx_q <= '0;
      word_q     <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      if (clear_i)       word_q <= '0;
      else if (accept_i) word_q <= word_o;
    end
  end

endmodule

// File: rtl/coeff_loader.sv
// Frame parser, checksum and shadow/active coefficient banks; the active bank only changes on commit.
module coeff_loader
  import coeff_pkg::*;
#(
  parameter int ORDER          = 41,
  parameter int COEFFDATAWIDTH = 32
) (
  input  logic                             Clk,
  input  logic                             Rst,
  coeff_loader_if.slave                    bus,
  output logic signed [COEFFDATAWIDTH-1:0] Coefficients [0:ORDER-1],
  output logic                             Busy,
  output logic                             Loaded,
  output logic                             LoadErr
);

  localparam int WW = (ORDER > 1) ? $clog2(ORDER) : 1;

  coeff_state_t state_q, state_d;
  logic [WW-1:0] word_idx_q, word_idx_d;
  logic [7:0]    sum_q, sum_d;
  logic          in_ready_q;
  logic          loaded_q, loaded_d;
  logic          load_err_q, load_err_d;
  logic          accept, data_accept, commit, word_done;
  logic [COEFFDATAWIDTH-1:0] asm_word;
  logic [COEFFDATAWIDTH-1:0] shadow_q [0:ORDER-1];
  logic [COEFFDATAWIDTH-1:0] coeff_q  [0:ORDER-1];

  assign accept      = bus.InValid && in_ready_q;
  assign data_accept = accept && !bus.Abort && (state_q == DATA);
  assign commit      = (state_q == COMMIT) && !bus.Abort;

  coeff_word_assembler #(
    .COEFFDATAWIDTH(COEFFDATAWIDTH)
  ) u_asm (
    .Clk      (Clk),
    .Rst      (Rst),
    .clear_i  (state_q != DATA),
    .accept_i (data_accept),
    .byte_i   (bus.InByte),
    .word_o   (asm_word),
    .WordDone (word_done)
  );

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    sum_d      = sum_q;
    loaded_d   = 1'b0;
    load_err_d = 1'b0;
    // Abort wins over anything else this edge, including the byte it coincides with.
    if (!bus.Abort) begin
      unique case (state_q)
        IDLE: begin
          if (accept && bus.InByte == SYNC_BYTE) begin
            state_d    = DATA;
            word_idx_d = '0;
            sum_d      = '0;
          end
        end
        DATA: begin
          if (accept) begin
            sum_d = sum_q + bus.InByte;
            if (word_done) begin
              if (word_idx_q == WW'(ORDER - 1)) state_d = CHECK;
              else                              word_idx_d = word_idx_q + WW'(1);
            end
          end
        end
        CHECK: begin
          if (accept) begin
            if (bus.InByte == sum_q) begin
              state_d = COMMIT;
            end else begin
              state_d    = IDLE;
              load_err_d = 1'b1;
            end
          end
        end
        COMMIT: begin
          state_d  = IDLE;
          loaded_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
      sum_q      <= '0;
      in_ready_q <= 1'b1;
      loaded_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      sum_q      <= sum_d;
      in_ready_q <= (state_d != COMMIT);
      loaded_q   <= loaded_d;
      load_err_q <= load_err_d;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < ORDER; i++) begin
        shadow_q[i] <= '0;
        coeff_q[i]  <= '0;
      end
    end else begin
      if (data_accept && word_done) shadow_q[word_idx_q] <= asm_word;
      if (commit) begin
        for (int i = 0; i < ORDER; i++) coeff_q[i] <= shadow_q[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ORDER; i++) Coefficients[i] = coeff_q[i];
  end

  assign bus.InReady = in_ready_q;
  assign Busy        = (state_q != IDLE);
  assign Loaded      = loaded_q;
  assign LoadErr     = load_err_q;

endmodule

// File: tb/tb_coeff_loader.sv
// Scoreboard bench for coeff_loader with ORDER=2, 32-bit coefficients.
module tb_coeff_loader;

  localparam int ORDER = 2;
  localparam int CW    = 32;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic signed [CW-1:0] coeffs [0:ORDER-1];
  logic Busy, Loaded, LoadErr;

  coeff_loader_if bus ();

  coeff_loader #(.ORDER(ORDER), .COEFFDATAWIDTH(CW)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .bus          (bus.slave),
    .Coefficients (coeffs),
    .Busy         (Busy),
    .Loaded       (Loaded),
    .LoadErr      (LoadErr)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;
  int n_loaded = 0, n_loaderr = 0, n_ready_low = 0;
  int exp_loaded = 0, exp_loaderr = 0;
  logic [2*CW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pops the expected bank on every Loaded pulse.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (!bus.InReady) n_ready_low++;
      if (LoadErr) n_loaderr++;
      if (Loaded && LoadErr) check("pulse_overlap", 32'(LoadErr), 0);
      if (Loaded) begin
        n_loaded++;
        if (exp_q.size() == 0) begin
          check("unexpected_loaded", 32'(Loaded), 0);
        end else begin
          logic [2*CW-1:0] e;
          e = exp_q.pop_front();
          check("sb_coeff0", coeffs[0], e[CW-1:0]);
          check("sb_coeff1", coeffs[1], e[2*CW-1:CW]);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    logic r;
    bus.InByte  = b;
    bus.InValid = 1'b1;
    forever begin
      r = bus.InReady;
      @(posedge Clk);
      n++;
      if (r) break;
      if (n >= 16) begin
        check("accept_timeout", 32'(r), 1);
        break;
      end
    end
    @(negedge Clk);
    bus.InValid = 1'b0;
  endtask

  task automatic send_frame(input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                            input bit force_cs, input logic [7:0] cs_val, input bit gaps);
    logic [CW-1:0] w [ORDER];
    logic [7:0] cs;
    cs = 8'h00;
    w[0] = c0;
    w[1] = c1;
    send_byte(8'hA5);
    for (int i = 0; i < ORDER; i++) begin
      for (int b = 0; b < CW/8; b++) begin
        if (gaps) idle($urandom_range(0, 2));
        send_byte(w[i][8*b +: 8]);
        cs = cs + w[i][8*b +: 8];
      end
    end
    if (!force_cs || cs_val == cs) begin
      exp_q.push_back({c1, c0});
      exp_loaded++;
    end else begin
      exp_loaderr++;
    end
    if (gaps) idle($urandom_range(0, 2));
    send_byte(force_cs ? cs_val : cs);
  endtask

  initial begin
    bus.InByte  = 8'h00;
    bus.InValid = 1'b0;
    bus.Abort   = 1'b0;
    idle(2);
    check("rst_coeff0", coeffs[0], 0);
    check("rst_coeff1", coeffs[1], 0);
    check("rst_inready", 32'(bus.InReady), 1);
    check("rst_busy", 32'(Busy), 0);
    check("rst_pulses", {30'd0, Loaded, LoadErr}, 0);
    Rst = 1'b0;
    idle(2);

    // Basic load: A5 01 00 00 00 FF FF FF FF FD
    send_frame(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 8'hFD, 1'b0);
    check("basic_commit_ready", 32'(bus.InReady), 0);
    check("basic_commit_loaded", 32'(Loaded), 0);
    idle(1);
    check("basic_loaded", 32'(Loaded), 1);
    check("basic_c0", coeffs[0], 32'h1);
    check("basic_c1", coeffs[1], 32'hFFFF_FFFF);
    check("basic_idle", 32'(Busy), 0);
    idle(1);
    check("basic_loaded_drop", 32'(Loaded), 0);

    // Bad checksum
    send_frame(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 8'h00, 1'b0);
    check("badcs_err", 32'(LoadErr), 1);
    check("badcs_idle", 32'(Busy), 0);
    idle(1);
    check("badcs_err_drop", 32'(LoadErr), 0);
    check("badcs_c0", coeffs[0], 32'h1);
    check("badcs_c1", coeffs[1], 32'hFFFF_FFFF);

    // Garbage before sync, then random gaps
    send_byte(8'h00);
    send_byte(8'h37);
    check("garbage_idle", 32'(Busy), 0);
    send_frame(32'h1234_5678, 32'h8000_0001, 1'b0, 8'h00, 1'b1);
    idle(2);
    check("gaps_c0", coeffs[0], 32'h1234_5678);
    check("gaps_c1", coeffs[1], 32'h8000_0001);

    // Abort on the edge accepting the 5th frame byte
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check("abort_busy_pre", 32'(Busy), 1);
    bus.InByte  = 8'h44;
    bus.InValid = 1'b1;
    bus.Abort   = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus.InValid = 1'b0;
    bus.Abort   = 1'b0;
    check("abort_busy", 32'(Busy), 0);
    check("abort_ready", 32'(bus.InReady), 1);
    idle(4);
    check("abort_pulses", 32'(n_loaded + n_loaderr), 32'(exp_loaded + exp_loaderr));
    check("abort_c0", coeffs[0], 32'h1234_5678);
    check("abort_c1", coeffs[1], 32'h8000_0001);
    send_frame(32'h0BAD_F00D, 32'h0000_0100, 1'b0, 8'h00, 1'b0);
    idle(2);
    check("post_abort_c0", coeffs[0], 32'h0BAD_F00D);

    // Sync value inside data
    send_frame(32'hA5A5_A5A5, 32'h7FFF_FFFF, 1'b0, 8'h00, 1'b0);
    idle(2);
    check("a5_c0", coeffs[0], 32'hA5A5_A5A5);
    check("a5_c1", coeffs[1], 32'h7FFF_FFFF);

    // Asynchronous reset during DATA
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    #2;
    Rst = 1'b1;
    #1;
    check("midrst_c0", coeffs[0], 0);
    check("midrst_c1", coeffs[1], 0);
    check("midrst_busy", 32'(Busy), 0);
    check("midrst_ready", 32'(bus.InReady), 1);
    idle(2);
    Rst = 1'b0;
    idle(1);
    send_frame(32'hDEAD_BEEF, 32'hFFFF_FF80, 1'b0, 8'h00, 1'b1);
    idle(2);
    check("postrst_c0", coeffs[0], 32'hDEAD_BEEF);
    check("postrst_c1", coeffs[1], 32'hFFFF_FF80);

    idle(3);
    check("total_loaded", 32'(n_loaded), 32'(exp_loaded));
    check("total_loaderr", 32'(n_loaderr), 32'(exp_loaderr));
    check("sb_empty", 32'(exp_q.size()), 0);
    check("ready_low_cycles", 32'(n_ready_low), 32'(exp_loaded));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule

// File: doc/coeff_loader.md
# coeff_loader

Runtime coefficient writer for the ECG FIR datapath. It receives a framed byte stream over a valid/ready handshake and assembles little-endian coefficient words into a shadow bank. It checks an 8-bit checksum, then commits the whole bank atomically to the `Coefficients` array consumed by the filter. The filter therefore never sees a partially written tap set, and the loaded taps can be retuned without resynthesis.

## Interface
Parameters:
- `ORDER`, default 41: number of coefficients; must match the filter's `ORDER`.
- `COEFFDATAWIDTH`, default 32: coefficient width in bits; must be a multiple of 8.

Ports:
- `Clk`, input, 1: single clock; all logic is on its rising edge.
- `Rst`, input, 1: reset, asynchronous, active-high.
- `InByte`, input, 8: stream byte.
- `InValid`, input, 1: `InByte` is valid.
- `InReady`, output, 1: block accepts a byte this cycle.
- `Abort`, input, 1: synchronous frame abort.
- `Coefficients`, output, signed [COEFFDATAWIDTH-1:0] [0:ORDER-1]: active coefficient bank.
- `Busy`, output, 1: a frame is in progress (state is not IDLE).
- `Loaded`, output, 1: one-cycle pulse; new bank is committed.
- `LoadErr`, output, 1: one-cycle pulse; checksum mismatch, frame discarded.

## Operation
- Frame format: sync byte `0xA5`, then ORDER×(COEFFDATAWIDTH/8) coefficient bytes, then one checksum byte.
  - Coefficient bytes are little-endian per word, with coefficient 0 first.
  - Checksum = sum of all coefficient bytes mod 256. The sync byte is excluded.
- Accept condition: `InValid && InReady` at a rising edge.
- States:
  - **IDLE**: `InReady`=1. Accepted `0xA5` → DATA; byte and word counters and the running sum are cleared. Any other accepted byte is discarded.
  - **DATA**: `InReady`=1. Each accepted byte goes into shadow[word][8·byte +: 8] and is added to the sum. After the last byte of word ORDER-1 → CHECK.
  - **CHECK**: `InReady`=1. Accepted byte equals the sum → COMMIT. Otherwise → IDLE with `LoadErr` pulsed.
  - **COMMIT**: `InReady`=0. Copies shadow to the active bank in one cycle, pulses `Loaded`, → IDLE.
- `Abort` high at an edge forces IDLE from any state and takes priority over a simultaneous byte accept; that byte is dropped. No `Loaded` or `LoadErr` is generated. The active bank is untouched.
- In DATA, a `0xA5` byte is data, not a resync.
- The shadow bank is never visible on the outputs. Partial contents after an abort or error are don't-care.
- The active bank changes only in COMMIT.

## Timing
- Reset values: `Coefficients` all zero, shadow all zero, state IDLE, `InReady`=1, `Busy`=0, `Loaded`=0, `LoadErr`=0.
- Reset asserted mid-frame returns to IDLE immediately and zeroes the active bank.
- Checksum byte accepted at edge E with a match:
  - COMMIT during cycle E..E+1.
  - New `Coefficients` and `Loaded`=1 are visible in the same cycle after edge E+1.
  - IDLE is resumed after E+1.
- Checksum mismatch at edge E: `LoadErr`=1 for exactly the cycle after E, and state is IDLE in that same cycle.
- Throughput: one byte per cycle. A minimum frame of 2+ORDER·COEFFDATAWIDTH/8 bytes commits 1 cycle after its last byte.
- `InReady` is a registered function of state only, with no combinational path from `InValid`.
- `Loaded` and `LoadErr` are registered and never high together.

## Structure
- Package `coeff_pkg` holds:
  - `SYNC_BYTE = 8'hA5`
  - `BYTES_PER_COEFF = COEFFDATAWIDTH/8`, via a function or localparam
  - state enum `coeff_state_t` {IDLE, DATA, CHECK, COMMIT}
- Sub-module `coeff_word_assembler` packs bytes into one COEFFDATAWIDTH word.
  - It holds the byte counter and a `WordDone` strobe.
  - The top level owns the word index, checksum, shadow and active banks, and the FSM.
- Counter widths: `$clog2(ORDER)` for the word index and `$clog2(BYTES_PER_COEFF)` for the byte index, each with a minimum of 1.

## Test plan
All scenarios use `ORDER`=2 and `COEFFDATAWIDTH`=32 unless stated.
- **Basic load**: reset, then stream A5 01 00 00 00 FF FF FF FF FD back-to-back. Expect `Coefficients[0]`=1 and `[1]`=-1, `Loaded` pulsing for 1 cycle, 1 cycle after the `FD` accept.
- **Bad checksum**: load the Basic-load bank, then send the same frame with checksum 00. Expect a `LoadErr` pulse, no `Loaded`, and the bank remains 1/-1.
- **Garbage and stalls**: bytes 00 37 before A5 are ignored; random `InValid` gaps inside the frame still commit correctly; `InReady`=0 only during COMMIT.
- **Abort**: assert `Abort` on the edge accepting the 5th byte. Expect IDLE, `Busy`=0, no pulses, and bank unchanged. A following full frame loads normally.
- **A5 in data**: coefficient bytes A5 A5 A5 A5 (value 0xA5A5A5A5) load correctly with no resync.
- **Reset mid-frame**: assert `Rst` asynchronously during DATA. Expect outputs zero immediately, `InReady`=1, and the next frame loads.
